// File: rtl/score_display_pkg.sv
// Shared constants, state enum and helpers for the score display.
// Segment patterns are active-low, bit0 = segment a.
`timescale 1ns/1ps
package score_disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_BITS = 16;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  function automatic logic [6:0] seg_of(
    input logic [3:0] n
  );
    logic [6:0] r;
    case (n)
      4'd0: r = SEG_0;
      4'd1: r = SEG_1;
      4'd2: r = SEG_2;
      4'd3: r = SEG_3;
      4'd4: r = SEG_4;
      4'd5: r = SEG_5;
      4'd6: r = SEG_6;
      4'd7: r = SEG_7;
      4'd8: r = SEG_8;
      4'd9: r = SEG_9;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  // Double-dabble pre-shift correction: nibbles >= 5 get +3.
  function automatic logic [BCD_BITS-1:0] dd_adj(
    input logic [BCD_BITS-1:0] v
  );
    logic [BCD_BITS-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction
endpackage

// File: rtl/score_display_if.sv
// Display-side outputs of score_display, bundled for the consumer.
`timescale 1ns/1ps
interface score_display_if;
  import score_disp_pkg::*;

  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  busy;
  logic [BCD_BITS-1:0]   bcd;

  modport master (
    output an, seg, dp, busy, bcd
  );

  modport slave (
    input an, seg, dp, busy, bcd
  );
endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter.
`timescale 1ns/1ps
module bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [13:0]         bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [BCD_BITS-1:0] bcd_o
);
  localparam logic [3:0] LAST = 4'd13;

  conv_state_e         state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [13:0]         bin_q, bin_d;
  logic [BCD_BITS-1:0] acc_q, acc_d;
  logic [BCD_BITS-1:0] bcd_q, bcd_d;
  logic [BCD_BITS-1:0] adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    adj     = dd_adj(acc_q);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = {adj[BCD_BITS-2:0], bin_q[13]};
        bin_d = {bin_q[12:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/score_display.sv
// Score synchroniser, BCD conversion and multiplexed 7-seg drive.
`timescale 1ns/1ps
module score_display
  import score_disp_pkg::*;
#(
  parameter int SCORE_W      = 15,
  parameter int DIGIT_CYCLES = 25000,
  parameter int MAX_DISP     = 9999
) (
  input  logic               dclk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_in,
  score_display_if.master    disp
);
  localparam int CNT_W =
    (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_DISP);

  logic [SCORE_W-1:0]  s1_q, s2_q, s3_q, last_q;
  logic                ovf_q, ovf_disp_q;
  logic [CNT_W-1:0]    scan_q;
  logic [1:0]          sel_q;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                start, busy_w, done_w;
  logic [13:0]         bin_w;
  logic [BCD_BITS-1:0] bcd_w;
  logic [3:0]          nib;
  logic                blank;

  // Only a value that held for two synchroniser stages is trusted.
  assign start = (s2_q == s3_q) && (s3_q != last_q) && !busy_w;
  assign bin_w = (s3_q > MAX_S) ? 14'(MAX_DISP) : 14'(s3_q);

  bin2bcd_seq u_conv (
    .clk     (dclk),
    .rst     (reset),
    .start_i (start),
    .bin_i   (bin_w),
    .busy_o  (busy_w),
    .done_o  (done_w),
    .bcd_o   (bcd_w)
  );

  always_ff @(posedge dclk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      last_q     <= '0;
      ovf_q      <= 1'b0;
      ovf_disp_q <= 1'b0;
      scan_q     <= '0;
      sel_q      <= '0;
      an_q       <= 4'hF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      s1_q <= score_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (start) begin
        last_q <= s3_q;
        ovf_q  <= (s3_q > MAX_S);
      end
      if (done_w)
        ovf_disp_q <= ovf_q;
      if (scan_q == CNT_LAST) begin
        scan_q <= '0;
        sel_q  <= sel_q + 2'd1;
      end else begin
        scan_q <= scan_q + CNT_W'(1);
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  // A digit blanks when it and every digit left of it are zero.
  always_comb begin
    nib   = bcd_w[3:0];
    blank = 1'b0;
    unique case (sel_q)
      2'd0: begin
        nib   = bcd_w[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = bcd_w[7:4];
        blank = (bcd_w[15:4] == '0);
      end
      2'd2: begin
        nib   = bcd_w[11:8];
        blank = (bcd_w[15:8] == '0);
      end
      2'd3: begin
        nib   = bcd_w[15:12];
        blank = (bcd_w[15:12] == '0);
      end
      default: ;
    endcase
    an_d  = ~(4'b0001 << sel_q);
    seg_d = blank ? SEG_BLANK : seg_of(nib);
    dp_d  = !((sel_q == 2'd3) && ovf_disp_q);
  end

  assign disp.an   = an_q;
  assign disp.seg  = seg_q;
  assign disp.dp   = dp_q;
  assign disp.busy = busy_w;
  assign disp.bcd  = bcd_w;
endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display with a short scan period.
`timescale 1ns/1ps
module tb_score_display;
  logic        dclk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] score_in = '0;

  score_display_if bus ();

  score_display #(
    .SCORE_W      (15),
    .DIGIT_CYCLES (4),
    .MAX_DISP     (9999)
  ) dut (
    .dclk     (dclk),
    .reset    (reset),
    .score_in (score_in),
    .disp     (bus.master)
  );

  always #5 dclk = ~dclk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  localparam logic [6:0] BL = 7'h7F;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Monitor: every completed conversion is checked against the queue.
  initial begin : monitor
    logic bprev;
    bprev = 1'b0;
    forever begin
      @(negedge dclk);
      #2;
      if (!reset && bprev && !bus.busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h required=none",
                   bus.bcd);
        end else begin
          chk("bcd_result", bus.bcd, exp_q.pop_front());
        end
      end
      bprev = reset ? 1'b0 : bus.busy;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge dclk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge dclk);
  endtask

  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpl);
    logic [6:0] es[4];
    bit seen[4];
    int k, nseen, bad;
    es = '{s0, s1, s2, s3};
    seen = '{0, 0, 0, 0};
    nseen = 0;
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge dclk);
      case (bus.an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        bad++;
      end else if (!seen[k]) begin
        seen[k] = 1;
        nseen++;
        chk($sformatf("seg_digit%0d", k), bus.seg, es[k]);
        chk($sformatf("dp_digit%0d", k), bus.dp, dpl[k]);
      end
    end
    chk("scan_all_digits", nseen, 4);
    chk("an_onehot", bad, 0);
  endtask

  task automatic convert(input logic [14:0] v, input logic [15:0] e);
    @(negedge dclk);
    score_in = v;
    exp_q.push_back(e);
    wait_drain(40);
    chk("bcd_final", bus.bcd, e);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bc, first;

    reset = 1'b1;
    repeat (3) @(negedge dclk);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_bcd", bus.bcd, 16'h0000);

    reset = 1'b0;
    @(negedge dclk);
    chk("first_an", bus.an, 4'b1110);
    chk("first_seg", bus.seg, 7'b1000000);
    chk("first_dp", bus.dp, 1'b1);
    bc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge dclk);
      if (bus.busy) bc++;
    end
    chk("idle_busy", bc, 0);
    scan_check(pat(0), BL, BL, BL, 4'hF);

    // 1234: busy for 15 cycles, bcd visible after edge E+18
    @(negedge dclk);
    score_in = 15'd1234;
    exp_q.push_back(16'h1234);
    bc = 0;
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge dclk);
      if (bus.busy) bc++;
      if (bus.bcd == 16'h1234 && first < 0) first = n;
    end
    chk("busy_cycles", bc, 15);
    chk("bcd_latency", first, 19);
    wait_drain(10);
    scan_check(pat(4), pat(3), pat(2), pat(1), 4'hF);

    convert(15'd7, 16'h0007);
    scan_check(7'b1111000, BL, BL, BL, 4'hF);

    convert(15'd32767, 16'h9999);
    scan_check(pat(9), pat(9), pat(9), pat(9), 4'b0111);

    convert(15'd50, 16'h0050);
    scan_check(pat(0), pat(5), BL, BL, 4'hF);

    // change during SHIFT: both values convert, in order
    @(negedge dclk);
    score_in = 15'd100;
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0200);
    repeat (6) @(negedge dclk);
    score_in = 15'd200;
    wait_drain(60);
    chk("mid_final", bus.bcd, 16'h0200);

    // reset in the middle of a conversion
    @(negedge dclk);
    score_in = 15'd9876;
    repeat (10) @(negedge dclk);
    chk("busy_before_abort", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_bcd", bus.bcd, 16'h0000);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_an", bus.an, 4'hF);
    repeat (2) @(negedge dclk);
    reset = 1'b0;
    exp_q.push_back(16'h9876);
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge dclk);
      if (bus.bcd == 16'h9876 && first < 0) first = n;
    end
    chk("restart_latency", first, 19);
    wait_drain(10);
    scan_check(pat(6), pat(7), pat(8), pat(9), 4'hF);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_display.md
# score_display

Downstream consumer of the rhythm-game playfield's 15-bit score bits. Synchronises the score from the game-logic clock domain into the pixel clock domain and converts it to 4-digit BCD with a sequential double-dabble engine. Drives a time-multiplexed, active-low 4-digit seven-segment display with leading-zero blanking and an overflow indicator.

## Interface

Parameters:
- SCORE_W, 15, score input width.
- DIGIT_CYCLES, 25000, dclk cycles each digit stays enabled (1 ms at 25 MHz).
- MAX_DISP, 9999, saturation value shown when the score exceeds 4 digits.

Ports:
- dclk  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-high.
- score_in  in  SCORE_W  binary score {score14..score0}; asynchronous to dclk.
- an  out  4  digit enables, active-low; an[0] = rightmost digit.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- busy  out  1  high while a conversion is in progress.
- bcd  out  16  current displayed BCD {d3,d2,d1,d0}, for visibility and verification.

## Operation

- **Synchroniser:** three-flop chain s1 ← score_in, s2 ← s1, s3 ← s2. The value is *stable* when s2 == s3; a multi-bit value is accepted only when stable.
- **Converter FSM** (states IDLE, SHIFT, DONE):
  - IDLE: if stable and s3 != last_val, then:
    - capture last_val ← s3;
    - set ovf ← (s3 > MAX_DISP);
    - load work_bin ← min(s3, MAX_DISP) (14 bits);
    - clear the BCD accumulator;
    - go to SHIFT with iteration count 0.
  - SHIFT: one double-dabble iteration per cycle. Every BCD nibble ≥ 5 gets +3, then {bcd, work_bin} shifts left 1. Exactly 14 iterations, then go to DONE.
  - DONE: bcd ← accumulator, ovf_disp ← ovf, then go to IDLE.
  - busy = (state != IDLE).
- score_in changes during SHIFT/DONE are ignored. On return to IDLE the comparison is re-evaluated, so the latest stable value is always converted eventually. Intermediate values may be skipped.
- **Scan:**
  - Counter scan_cnt counts 0..DIGIT_CYCLES-1. On wrap, the digit index sel advances 0→1→2→3→0.
  - an = ~(1 << sel).
  - seg = the pattern for nibble d[sel].
- **Leading-zero blanking:** digit k (k ≥ 1) is blank (seg = 7'h7F) when d3..dk are all zero. Digit 0 is never blanked.
- **Overflow indicator:** dp = 0 only when sel == 3 and ovf_disp == 1; otherwise dp = 1.
- Nibble values 10–15 cannot occur; they display blank.

## Timing

- **Reset values:**
  - an = 4'b1111, seg = 7'h7F, dp = 1, busy = 0, bcd = 16'h0000;
  - state = IDLE, s1/s2/s3 = 0, last_val = 0, ovf_disp = 0, scan_cnt = 0, sel = 0.
- First rising edge after reset release: an = 4'b1110, seg = "0" (7'b1000000).
- an, seg and dp are registered and follow sel with 1 cycle of latency.
- **Conversion latency:**
  - Edge E samples a new constant value into s1.
  - The IDLE capture occurs on E+3.
  - The 14 SHIFT edges are E+4..E+17.
  - bcd updates on E+18.
  - busy is high from E+3+1 through E+18.
- A displayed digit changes at most one cycle after bcd updates. No blank frame is inserted.
- Reset asserted mid-SHIFT aborts immediately. All state returns to reset values and bcd reads 0; no partial result is ever exposed.
- Simultaneous new stable value and DONE: DONE completes; the new value is captured on the following IDLE cycle.
- scan_cnt wrap and a bcd update on the same edge: the new sel uses the new bcd on the next edge.

## Structure

- Package score_disp_pkg holds:
  - the SEG_0..SEG_9 active-low patterns and SEG_BLANK;
  - NUM_DIGITS = 4 and BCD_BITS = 16;
  - the converter state enum (IDLE, SHIFT, DONE).
- Sub-module bin2bcd_seq: the converter FSM.
  - Inputs: start and a 14-bit bin.
  - Outputs: busy, done pulse and a 16-bit bcd.
  - The top level holds the synchroniser, last_val/ovf logic, scan counter, blanking and segment decode.

## Test plan

- **Reset:** assert reset, release, score_in = 0 → an = 4'b1110, seg = 7'b1000000, dp = 1, digits 1–3 blank; busy never rises.
- **Conversion:** score_in = 1234 → busy high for 15 cycles; bcd = 16'h1234 on E+18. With DIGIT_CYCLES = 4, scan shows digits 4, 3, 2, 1 at an = 1110, 1101, 1011, 0111.
- **Blanking:** score_in = 7 → bcd = 16'h0007; digits 1–3 seg = 7'h7F; digit 0 seg = 7'b1111000.
- **Saturation:** score_in = 32767 → bcd = 16'h9999, dp = 0 only while an = 4'b0111. Then score_in = 50 → dp = 1 everywhere, bcd = 16'h0050.
- **Mid-conversion change:** score_in = 100, then 200 at E+6 → bcd shows 0100, then 0200 within 20 cycles of the second conversion start. Final bcd = 16'h0200.
- **Reset mid-SHIFT:** assert reset at E+10 of a conversion of 9876 → bcd = 0 and busy = 0 immediately. After release with score_in still 9876, bcd = 16'h9876 after 18 edges.
